// File: rtl/bpsk_tx_ctrl_if.sv
// Payload handshake and symbol-stream signals of the BPSK transmit frame controller.
// master = payload source / observer, slave = the controller itself.
interface bpsk_tx_ctrl_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       code;
  logic       code_en;
  logic       sym_stb;
  logic       frame_start;
  logic       frame_done;
  logic       underrun;
  logic       busy;

  modport master (
    output din, din_valid,
    input  din_ready, code, code_en, sym_stb, frame_start, frame_done, underrun, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, code, code_en, sym_stb, frame_start, frame_done, underrun, busy
  );
endinterface

// File: rtl/bpsk_tx_ctrl.sv
// BPSK transmit frame controller: preamble + FRAME_BYTES payload bytes, MSB first,
// one code bit per SPS-cycle symbol, followed by a silent guard gap.
module bpsk_tx_ctrl #(
  parameter int          SPS         = 8,
  parameter int          PRE_LEN     = 16,
  parameter logic [31:0] PRE_PATTERN = 32'h0000_AAAA,
  parameter int          FRAME_BYTES = 4,
  parameter int          GAP_SYM     = 4
) (
  input logic           clk,
  input logic           rst,
  bpsk_tx_ctrl_if.slave bus
);

  localparam int SW   = $clog2(SPS);
  localparam int BMAX = (PRE_LEN > 8) ? ((PRE_LEN > GAP_SYM) ? PRE_LEN : GAP_SYM)
                                      : ((GAP_SYM > 8) ? GAP_SYM : 8);
  localparam int BW   = $clog2(BMAX);
  localparam int AW   = $clog2(FRAME_BYTES + 1);

  localparam logic [SW-1:0] SCNT_LAST = SW'(SPS - 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'(PRE_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(7);
  localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_SYM - 1);
  localparam logic [AW-1:0] FB        = AW'(FRAME_BYTES);
  localparam logic [AW-1:0] FB_LAST   = AW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [AW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [AW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            nbuf_v_q, nbuf_v_d;
  logic [7:0]      nbuf_q, nbuf_d;
  logic [7:0]      sreg_q, sreg_d;

  logic            code_q, code_d;
  logic            code_en_q, code_en_d;
  logic            sym_stb_q, sym_stb_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            underrun_q, underrun_d;
  logic            busy_q, busy_d;

  logic            din_ready;
  logic            accept;
  logic            sym_end;
  logic [SW-1:0]   scnt_inc;
  logic            last_d;

  function automatic logic pre_bit(input logic [BW-1:0] b);
    logic [4:0] idx;
    idx = 5'(PRE_LEN - 1 - int'(b));
    return PRE_PATTERN[idx];
  endfunction

  function automatic logic [AW-1:0] acc_inc(input logic [AW-1:0] a);
    return (a >= FB) ? FB : a + 1'b1;
  endfunction

  always_comb begin
    din_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:      din_ready = 1'b1;
        PRE, DATA: din_ready = !nbuf_v_q && (acc_cnt_q < FB);
        default:   din_ready = 1'b0;
      endcase
    end
  end

  assign accept   = bus.din_valid && din_ready;
  assign sym_end  = (scnt_q == SCNT_LAST);
  assign scnt_inc = sym_end ? '0 : scnt_q + 1'b1;

  // Next state: state/counter registers describe the cycle currently on the outputs.
  // An abort is decided one cycle early (underrun_q is high on the byte's last cycle),
  // so the reload point simply follows that registered decision.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    acc_cnt_d  = acc_cnt_q;
    byte_cnt_d = byte_cnt_q;
    nbuf_v_d   = nbuf_v_q;
    nbuf_d     = nbuf_q;
    sreg_d     = sreg_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = PRE;
          scnt_d     = '0;
          bcnt_d     = '0;
          byte_cnt_d = '0;
          acc_cnt_d  = '0;
        end
      end
      PRE: begin
        scnt_d = scnt_inc;
        if (sym_end) begin
          if (bcnt_q == PRE_LAST) begin
            bcnt_d = '0;
            if (nbuf_v_q && !underrun_q) begin
              state_d  = DATA;
              sreg_d   = nbuf_q;
              nbuf_v_d = 1'b0;
            end else begin
              state_d = GAP;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        scnt_d = scnt_inc;
        if (sym_end) begin
          sreg_d = {sreg_q[6:0], 1'b0};
          if (bcnt_q == BIT_LAST) begin
            bcnt_d     = '0;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == FB_LAST) begin
              state_d = GAP;
            end else if (nbuf_v_q && !underrun_q) begin
              sreg_d   = nbuf_q;
              nbuf_v_d = 1'b0;
            end else begin
              state_d = GAP;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        scnt_d     = scnt_inc;
        acc_cnt_d  = '0;
        byte_cnt_d = '0;
        nbuf_v_d   = 1'b0;
        if (sym_end) begin
          if (bcnt_q == GAP_LAST) begin
            state_d = IDLE;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte taken on the same cycle the buffer is unloaded wins: the buffer stays full.
    if (accept) begin
      nbuf_d    = bus.din;
      nbuf_v_d  = 1'b1;
      acc_cnt_d = acc_inc(acc_cnt_d);
    end
  end

  // Registered outputs are decoded from the next-cycle state so they line up with it.
  always_comb begin
    busy_d        = (state_d != IDLE);
    code_en_d     = (state_d == PRE) || (state_d == DATA);
    sym_stb_d     = code_en_d && (scnt_d == '0);
    frame_start_d = (state_q == IDLE) && (state_d == PRE);
    unique case (state_d)
      PRE:     code_d = pre_bit(bcnt_d);
      DATA:    code_d = sreg_d[7];
      default: code_d = 1'b0;
    endcase
    last_d = (scnt_d == SCNT_LAST) &&
             (((state_d == PRE) && (bcnt_d == PRE_LAST)) ||
              ((state_d == DATA) && (bcnt_d == BIT_LAST)));
    frame_done_d = last_d && (state_d == DATA) && (byte_cnt_d == FB_LAST);
    underrun_d   = last_d && !frame_done_d && !nbuf_v_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      scnt_q        <= '0;
      bcnt_q        <= '0;
      acc_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      nbuf_v_q      <= 1'b0;
      code_q        <= 1'b0;
      code_en_q     <= 1'b0;
      sym_stb_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      bcnt_q        <= bcnt_d;
      acc_cnt_q     <= acc_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      nbuf_v_q      <= nbuf_v_d;
      code_q        <= code_d;
      code_en_q     <= code_en_d;
      sym_stb_q     <= sym_stb_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
      busy_q        <= busy_d;
    end
  end

  // Byte storage carries no reset; nbuf_v_q and the state qualify its contents.
  always_ff @(posedge clk) begin
    nbuf_q <= nbuf_d;
    sreg_q <= sreg_d;
  end

  assign bus.din_ready   = din_ready;
  assign bus.code        = code_q;
  assign bus.code_en     = code_en_q;
  assign bus.sym_stb     = sym_stb_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.underrun    = underrun_q;
  assign bus.busy        = busy_q;

endmodule
